// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : pll_supervisor
//  Purpose  : Sequences the PLL reset, waits for lock with timeout/retry,
//             qualifies lock stability, holds the downstream system reset for
//             a fixed time, and relocks whenever lock is lost. Runs entirely
//             on the free-running board clock, never on a PLL output.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clkin          in   1      board clock, free-running
//    rst            in   1      synchronous active-high reset
//    locked         in   1      PLL lock flag, asynchronous to clkin
//    pll_rst        out  1      reset to the PLL
//    sys_rst        out  1      active-high reset for downstream logic
//    ready          out  1      high only while in RUN
//    lock_sync      out  1      locked after a 2-flop synchronizer
//    timeout_count  out  CNT_W  WAIT_LOCK timeouts, saturating
//    relock_count   out  CNT_W  lock losses seen in RUN, saturating
// ============================================================================
module pll_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1000000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int CNT_W          = 8
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             lock_sync,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] relock_count
);

    // Timer is sized for the longest of the four intervals, plus one bit.
    localparam int c_max_ab = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_max_cd = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int c_max    = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_tmr_w  = $clog2(c_max) + 1;

    localparam logic [c_tmr_w-1:0] c_rst_last    = c_tmr_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_lock_last   = c_tmr_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_stable_last = c_tmr_w'(STABLE_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_hold_last   = c_tmr_w'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max     = '1;

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [c_tmr_w-1:0]   timer_q;
    logic [c_tmr_w-1:0]   timer_d;
    logic                 sync1_q;
    logic                 lock_sync_q;
    logic                 pll_rst_q;
    logic                 sys_rst_q;
    logic                 ready_q;
    logic [CNT_W-1:0]     timeout_q;
    logic [CNT_W-1:0]     relock_q;
    logic                 timeout_inc_d;
    logic                 relock_inc_d;

    // Next-state decode. Only the synchronized lock flag is ever consulted.
    always_comb begin
        state_d       = state_q;
        timeout_inc_d = 1'b0;
        relock_inc_d  = 1'b0;
        case (state_q)
            S_RESET_PLL: begin
                if (timer_q == c_rst_last) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock wins over a timeout landing on the same edge.
                if (lock_sync_q) begin
                    state_d = S_STABLE;
                end else if (timer_q == c_lock_last) begin
                    state_d       = S_RESET_PLL;
                    timeout_inc_d = 1'b1;
                end
            end
            S_STABLE: begin
                // Lock dropped before being trusted: wait again, PLL not reset.
                if (!lock_sync_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (timer_q == c_stable_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!lock_sync_q) begin
                    state_d = S_RESET_PLL;
                end else if (timer_q == c_hold_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_sync_q) begin
                    state_d      = S_RESET_PLL;
                    relock_inc_d = 1'b1;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        // Timer restarts on every state change; RUN has no interval to time.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == S_RUN) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as the transition that causes them.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            lock_sync_q <= 1'b0;
            state_q     <= S_RESET_PLL;
            timer_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            timeout_q   <= '0;
            relock_q    <= '0;
        end else begin
            sync1_q     <= locked;
            lock_sync_q <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            pll_rst_q   <= (state_d == S_RESET_PLL);
            sys_rst_q   <= (state_d != S_RUN);
            ready_q     <= (state_d == S_RUN);
            if (timeout_inc_d && (timeout_q != c_cnt_max)) begin
                timeout_q <= timeout_q + 1'b1;
            end
            if (relock_inc_d && (relock_q != c_cnt_max)) begin
                relock_q <= relock_q + 1'b1;
            end
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign lock_sync     = lock_sync_q;
    assign timeout_count = timeout_q;
    assign relock_count  = relock_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_supervisor
//  Purpose  : Directed stimulus for pll_supervisor. Each scenario pushes its
//             hand-computed expected outputs, tagged with the absolute clock
//             edge they apply after, into a scoreboard; a monitor compares the
//             DUT outputs on every falling edge against due entries.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 50;
    localparam int P_STAB = 8;
    localparam int P_HOLD = 6;
    localparam int P_CW   = 8;

    logic            clkin  = 1'b0;
    logic            rst    = 1'b1;
    logic            locked = 1'b0;
    logic            pll_rst;
    logic            sys_rst;
    logic            ready;
    logic            lock_sync;
    logic [P_CW-1:0] timeout_count;
    logic [P_CW-1:0] relock_count;

    pll_supervisor #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .STABLE_CYCLES  (P_STAB),
        .HOLD_CYCLES    (P_HOLD),
        .CNT_W          (P_CW)
    ) dut (
        .clkin         (clkin),
        .rst           (rst),
        .locked        (locked),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .lock_sync     (lock_sync),
        .timeout_count (timeout_count),
        .relock_count  (relock_count)
    );

    always #5 clkin = ~clkin;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        int           at;
        logic [127:0] nm;
        logic         pr;
        logic         sr;
        logic         rd;
        int           ls;   // -1: not checked
        logic [7:0]   tc;
        logic [7:0]   rc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Sorted insert so scenarios may push in any order.
    task automatic push(input int at, input logic [127:0] nm, input logic pr,
                        input logic sr, input logic rd, input int ls,
                        input logic [7:0] tc, input logic [7:0] rc);
        exp_t e;
        int   i;
        e.at = at; e.nm = nm; e.pr = pr; e.sr = sr; e.rd = rd;
        e.ls = ls; e.tc = tc; e.rc = rc;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    task automatic cmp(input logic [127:0] nm, input string fld, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %0s.%0s at edge %0d: got %0d expected %0d", nm, fld, cyc, act, req);
        end
    endtask

    // Monitor: compare every entry that has come due.
    always @(negedge clkin) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            cmp(e.nm, "pll_rst", int'(pll_rst), int'(e.pr));
            cmp(e.nm, "sys_rst", int'(sys_rst), int'(e.sr));
            cmp(e.nm, "ready",   int'(ready),   int'(e.rd));
            if (e.ls >= 0) cmp(e.nm, "lock_sync", int'(lock_sync), e.ls);
            cmp(e.nm, "timeout_count", int'(timeout_count), int'(e.tc));
            cmp(e.nm, "relock_count",  int'(relock_count),  int'(e.rc));
        end
    end

    // Advance to just after rising edge c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clkin);
            #1;
        end
    endtask

    // Two edges of reset, check reset values, release. Returns the edge
    // after which rst is low.
    task automatic do_reset(output int c);
        rst    = 1'b1;
        locked = 1'b0;
        goto(cyc + 2);
        push(cyc, "reset", 1'b1, 1'b1, 1'b0, 0, 8'd0, 8'd0);
        rst = 1'b0;
        c   = cyc;
    endtask

    // From RUN, drop locked for 3 edges at edge d, then restore it.
    task automatic relock(input int d, input logic [7:0] rc0, input logic [7:0] tcv);
        logic [7:0] rc1;
        rc1 = rc0 + 8'd1;
        push(d + 1,  "rl_pre",     1'b0, 1'b0, 1'b1, 1,  tcv, rc0);
        push(d + 2,  "rl_still",   1'b0, 1'b0, 1'b1, 0,  tcv, rc0);
        push(d + 3,  "rl_drop",    1'b1, 1'b1, 1'b0, 0,  tcv, rc1);
        push(d + 6,  "rl_prst_hi", 1'b1, 1'b1, 1'b0, 1,  tcv, rc1);
        push(d + 7,  "rl_prst_lo", 1'b0, 1'b1, 1'b0, 1,  tcv, rc1);
        push(d + 21, "rl_pre_run", 1'b0, 1'b1, 1'b0, 1,  tcv, rc1);
        push(d + 22, "rl_run",     1'b0, 1'b0, 1'b1, 1,  tcv, rc1);
        goto(d);
        locked = 1'b0;
        goto(d + 3);
        locked = 1'b1;
        goto(d + 22);
    endtask

    initial begin
        int c;
        int b;
        int e;

        // Timeouts, retry period of 4+50 edges, then saturation.
        do_reset(c);
        push(c + 3,        "t1_prst_hi", 1'b1, 1'b1, 1'b0, 0, 8'd0,   8'd0);
        push(c + 4,        "t1_prst_lo", 1'b0, 1'b1, 1'b0, 0, 8'd0,   8'd0);
        push(c + 53,       "t1_pre_to",  1'b0, 1'b1, 1'b0, 0, 8'd0,   8'd0);
        push(c + 54,       "t1_to1",     1'b1, 1'b1, 1'b0, 0, 8'd1,   8'd0);
        push(c + 108,      "t1_to2",     1'b1, 1'b1, 1'b0, 0, 8'd2,   8'd0);
        push(c + 162,      "t1_to3",     1'b1, 1'b1, 1'b0, 0, 8'd3,   8'd0);
        push(c + 54 * 254, "t5_to254",   1'b1, 1'b1, 1'b0, 0, 8'd254, 8'd0);
        push(c + 54 * 255, "t5_to255",   1'b1, 1'b1, 1'b0, 0, 8'd255, 8'd0);
        push(c + 54 * 256, "t5_sat256",  1'b1, 1'b1, 1'b0, 0, 8'd255, 8'd0);
        push(c + 54 * 300, "t5_sat300",  1'b1, 1'b1, 1'b0, 0, 8'd255, 8'd0);
        push(c + 54 * 300 + 4, "t5_prst_lo", 1'b0, 1'b1, 1'b0, 0, 8'd255, 8'd0);
        goto(c + 54 * 300 + 5);

        // Lock 10 cycles after pll_rst falls; RUN 17 edges after first sample.
        do_reset(c);
        push(c + 4,  "t2_prst_lo", 1'b0, 1'b1, 1'b0, 0, 8'd0, 8'd0);
        push(c + 15, "t2_ls_lo",   1'b0, 1'b1, 1'b0, 0, 8'd0, 8'd0);
        push(c + 16, "t2_ls_hi",   1'b0, 1'b1, 1'b0, 1, 8'd0, 8'd0);
        push(c + 30, "t2_pre_run", 1'b0, 1'b1, 1'b0, 1, 8'd0, 8'd0);
        push(c + 31, "t2_run",     1'b0, 1'b0, 1'b1, 1, 8'd0, 8'd0);
        goto(c + 14);
        locked = 1'b1;
        goto(c + 40);
        relock(c + 40, 8'd0, 8'd0);

        // One timeout, then a glitch during STABLE restarts qualification;
        // two relocks, then a one-cycle rst from RUN.
        do_reset(c);
        b = c + 54;
        push(b,      "t3_to1",       1'b1, 1'b1, 1'b0, 0, 8'd1, 8'd0);
        push(b + 4,  "t3_prst_lo",   1'b0, 1'b1, 1'b0, 0, 8'd1, 8'd0);
        push(b + 6,  "t3_ls_hi",     1'b0, 1'b1, 1'b0, 1, 8'd1, 8'd0);
        push(b + 12, "t3_back_wait", 1'b0, 1'b1, 1'b0, 0, 8'd1, 8'd0);
        push(b + 21, "t3_requal",    1'b0, 1'b1, 1'b0, 1, 8'd1, 8'd0);
        push(b + 28, "t3_pre_run",   1'b0, 1'b1, 1'b0, 1, 8'd1, 8'd0);
        push(b + 29, "t3_run",       1'b0, 1'b0, 1'b1, 1, 8'd1, 8'd0);
        goto(b + 4);
        locked = 1'b1;
        goto(b + 9);
        locked = 1'b0;
        goto(b + 12);
        locked = 1'b1;
        goto(b + 30);
        relock(b + 35, 8'd0, 8'd1);
        relock(b + 65, 8'd1, 8'd1);

        e = b + 95;
        push(e,     "t6_pre_rst", 1'b0, 1'b0, 1'b1, 1,  8'd1, 8'd2);
        push(e + 1, "t6_rst",     1'b1, 1'b1, 1'b0, 0,  8'd0, 8'd0);
        push(e + 4, "t6_prst_hi", 1'b1, 1'b1, 1'b0, -1, 8'd0, 8'd0);
        push(e + 5, "t6_prst_lo", 1'b0, 1'b1, 1'b0, -1, 8'd0, 8'd0);
        goto(e);
        rst = 1'b1;
        goto(e + 1);
        rst = 1'b0;
        goto(e + 6);

        goto(cyc + 4);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            total += sb.size();
            bad   += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
